// File: rtl/arki_isa_pkg.sv
// LEGv8 encoding constants shared by the instruction encoder and the main decoder.
// Holds instruction kinds, opcodes, field widths and immediate ranges.
package arki_isa_pkg;

  localparam int KIND_W = 4;
  localparam int REG_W  = 5;

  typedef enum logic [KIND_W-1:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_ORR  = 4'd3,
    KIND_ADDI = 4'd4,
    KIND_LDUR = 4'd5,
    KIND_STUR = 4'd6,
    KIND_CBZ  = 4'd7,
    KIND_CBNZ = 4'd8
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  localparam int ADDI_IMM_W = 12;
  localparam int D_IMM_W    = 9;
  localparam int CB_IMM_W   = 19;

  localparam int ADDI_IMM_MIN = 0;
  localparam int ADDI_IMM_MAX = 4095;
  localparam int D_IMM_MIN    = -256;
  localparam int D_IMM_MAX    = 255;
  localparam int CB_IMM_MIN   = -(1 << 18);
  localparam int CB_IMM_MAX   = (1 << 18) - 1;

  function automatic logic imm_in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request stream into the encoder plus the instruction-memory write port out of it.
interface instr_encoder_if
  import arki_isa_pkg::*;
#(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [KIND_W-1:0] in_kind;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rn;
  logic [REG_W-1:0]  in_rm;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_rd, in_rn, in_rm, in_imm, in_last,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rn, in_rm, in_imm, in_last,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/instr_format.sv
// Combinational packer: symbolic request -> 32-bit LEGv8 word, plus illegal-kind
// and immediate-range flags. Fields are truncated to width after the range test.
module instr_format
  import arki_isa_pkg::*;
(
  input  logic [KIND_W-1:0] kind,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rn,
  input  logic [REG_W-1:0]  rm,
  input  logic [31:0]       imm,
  output logic [31:0]       word,
  output logic              illegal,
  output logic              range_err
);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (kind)
      KIND_ADD:  word = {OP_ADD, rm, 6'd0, rn, rd};
      KIND_SUB:  word = {OP_SUB, rm, 6'd0, rn, rd};
      KIND_AND:  word = {OP_AND, rm, 6'd0, rn, rd};
      KIND_ORR:  word = {OP_ORR, rm, 6'd0, rn, rd};
      KIND_ADDI: begin
        word      = {OP_ADDI, imm[ADDI_IMM_W-1:0], rn, rd};
        range_err = !imm_in_range(imm, ADDI_IMM_MIN, ADDI_IMM_MAX);
      end
      KIND_LDUR: begin
        word      = {OP_LDUR, imm[D_IMM_W-1:0], 2'b00, rn, rd};
        range_err = !imm_in_range(imm, D_IMM_MIN, D_IMM_MAX);
      end
      KIND_STUR: begin
        word      = {OP_STUR, imm[D_IMM_W-1:0], 2'b00, rn, rd};
        range_err = !imm_in_range(imm, D_IMM_MIN, D_IMM_MAX);
      end
      // Branch forms carry no Rn; Rt sits in the Rd slot.
      KIND_CBZ: begin
        word      = {OP_CBZ, imm[CB_IMM_W-1:0], rd};
        range_err = !imm_in_range(imm, CB_IMM_MIN, CB_IMM_MAX);
      end
      KIND_CBNZ: begin
        word      = {OP_CBNZ, imm[CB_IMM_W-1:0], rd};
        range_err = !imm_in_range(imm, CB_IMM_MIN, CB_IMM_MAX);
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming encoder / instruction-memory loader: IDLE -> LOAD -> DONE session FSM.
// Define ENC_RANGE_CHECK_EN to drop out-of-range immediates and flag them on err.
module instr_encoder
  import arki_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic [ADDR_W:0] count,
  output logic            done,
  output logic            err,
  output logic            overflow
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;
  logic              ovf_reg, ovf_next;
  logic              fin_reg, fin_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;

  logic [31:0]       word;
  logic              illegal;
  logic              range_err;
  logic              full;
  logic              ready;
  logic              accept;
  logic              drop;
  logic              write;
  logic              fills;
  logic [ADDR_W:0]   count_inc;

  instr_format u_format (
    .kind      (bus.in_kind),
    .rd        (bus.in_rd),
    .rn        (bus.in_rn),
    .rm        (bus.in_rm),
    .imm       (bus.in_imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  // fin_reg holds off further beats for the one cycle the final write is on the bus.
  assign full      = (count_reg == CAP);
  assign ready     = (state_reg == ST_LOAD) && !full && !fin_reg;
  assign accept    = bus.in_valid && ready;
  assign drop      = illegal || (RANGE_CHECK && range_err);
  assign write     = accept && !drop;
  assign count_inc = count_reg + 1'b1;
  assign fills     = write && (count_inc == CAP);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    ovf_next   = ovf_reg;
    fin_next   = fin_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          count_next = '0;
          err_next   = 1'b0;
          ovf_next   = 1'b0;
          fin_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (fin_reg) begin
          state_next = ST_DONE;
          fin_next   = 1'b0;
        end else if (full) begin
          // Only reachable when BASE_ADDR leaves no room at all.
          state_next = ST_DONE;
          ovf_next   = 1'b1;
        end else if (accept) begin
          if (drop) begin
            err_next = 1'b1;
          end
          if (write) begin
            we_next    = 1'b1;
            waddr_next = BASE + count_reg[ADDR_W-1:0];
            wdata_next = word;
            count_next = count_inc;
          end
          if (bus.in_last || fills) begin
            fin_next = 1'b1;
          end
          if (fills && !bus.in_last) begin
            ovf_next = 1'b1;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      err_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      fin_reg   <= 1'b0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      ovf_reg   <= ovf_next;
      fin_reg   <= fin_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_reg;
  assign bus.imem_waddr = waddr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign count          = count_reg;
  assign done           = (state_reg == ST_DONE);
  assign err            = err_reg;
  assign overflow       = ovf_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed beats push expected writes, a
// negedge monitor pops and compares every write strobe on two DUT instances.
module tb_instr_encoder;
  import arki_isa_pkg::*;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(6)) a_if ();
  instr_encoder_if #(.ADDR_W(2)) b_if ();

  logic [6:0] count_a;
  logic [2:0] count_b;
  logic done_a, err_a, ovf_a, done_b, err_b, ovf_b;

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bus(a_if.slave),
    .count(count_a), .done(done_a), .err(err_a), .overflow(ovf_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(b_if.slave),
    .count(count_b), .done(done_b), .err(err_b), .overflow(ovf_b)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  logic [5:0] next_a = '0;
  logic [1:0] next_b = '0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    wr_t e;
    if (a_if.imem_we) begin
      if (q_a.size() == 0) begin
        chk("wr_a_unexpected", {26'd0, a_if.imem_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        chk("wr_a_addr", {26'd0, a_if.imem_waddr}, {26'd0, e.addr});
        chk("wr_a_data", a_if.imem_wdata, e.data);
      end
    end
    if (b_if.imem_we) begin
      if (q_b.size() == 0) begin
        chk("wr_b_unexpected", {30'd0, b_if.imem_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        chk("wr_b_addr", {30'd0, b_if.imem_waddr}, {26'd0, e.addr});
        chk("wr_b_data", b_if.imem_wdata, e.data);
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input logic [3:0] k, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [31:0] imm, input bit last);
    if (!sel) begin
      a_if.in_valid = v; a_if.in_kind = k; a_if.in_rd = rd; a_if.in_rn = rn;
      a_if.in_rm = rm; a_if.in_imm = imm; a_if.in_last = last;
    end else begin
      b_if.in_valid = v; b_if.in_kind = k; b_if.in_rd = rd; b_if.in_rn = rn;
      b_if.in_rm = rm; b_if.in_imm = imm; b_if.in_last = last;
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (!sel) begin start_a = 1'b1; next_a = '0; end
    else begin start_b = 1'b1; next_b = '0; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Call at posedge+1; returns at posedge+1 after acceptance with valid still high.
  task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [31:0] imm, input bit last,
                      input bit exp_we, input logic [31:0] exp_data);
    drive(sel, 1'b1, k, rd, rn, rm, imm, last);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? b_if.in_ready : a_if.in_ready) begin
        if (exp_we) begin
          if (!sel) begin q_a.push_back({next_a, exp_data}); next_a++; end
          else begin q_b.push_back({4'd0, next_b, exp_data}); next_b++; end
        end
        $display("beat dut=%0d kind=%0d rd=%0d rn=%0d rm=%0d imm=%0d last=%0b", sel, k, rd, rn, rm,
                 $signed(imm), last);
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout dut=%0d kind=%0d actual=not_ready required=ready", sel, k);
    idle(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_acc;
    bit seen_done;
    idle(1'b0);
    idle(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, a_if.imem_we}, 32'd0);
    chk("rst_waddr", {26'd0, a_if.imem_waddr}, 32'd0);
    chk("rst_wdata", a_if.imem_wdata, 32'd0);
    chk("rst_count", {25'd0, count_a}, 32'd0);
    chk("rst_flags", {28'd0, done_a, err_a, ovf_a, a_if.in_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_if.in_ready}, 32'd0);
    sync();
    reset_n = 1'b1;

    // ADD X1,X2,X3 alone: done two cycles after acceptance
    pulse_start(1'b0);
    send(1'b0, KIND_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 1'b1, 32'h8B03_0041);
    idle(1'b0);
    @(negedge clk);
    chk("t1_done_wr_cycle", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, done_a}, 32'd1);
    chk("t1_count", {25'd0, count_a}, 32'd1);
    @(negedge clk);
    chk("t1_done_low", {31'd0, done_a}, 32'd0);

    // Back-to-back LDUR / CBZ
    pulse_start(1'b0);
    send(1'b0, KIND_LDUR, 5'd5, 5'd6, 5'd0, 32'd8, 1'b0, 1'b1, 32'hF840_80C5);
    send(1'b0, KIND_CBZ, 5'd7, 5'd0, 5'd0, -32'sd2, 1'b1, 1'b1, 32'hB4FF_FFC7);
    idle(1'b0);
    @(negedge clk);
    chk("t2_second_wr_we", {31'd0, a_if.imem_we}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_count", {25'd0, count_a}, 32'd2);

    // ADDI immediate boundary
    pulse_start(1'b0);
    send(1'b0, KIND_ADDI, 5'd1, 5'd1, 5'd0, 32'd4095, 1'b0, 1'b1, 32'h913F_FC21);
    send(1'b0, KIND_ADDI, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b1, !RC, 32'h9100_0021);
    idle(1'b0);
    @(negedge clk);
    chk("t3_err", {31'd0, err_a}, {31'd0, RC});
    repeat (2) @(negedge clk);
    chk("t3_count", {25'd0, count_a}, RC ? 32'd1 : 32'd2);

    // Illegal kind mid-stream
    pulse_start(1'b0);
    send(1'b0, KIND_ADD, 5'd4, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h8B03_0044);
    send(1'b0, 4'hF, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 32'd0);
    idle(1'b0);
    @(negedge clk);
    chk("t4_err", {31'd0, err_a}, 32'd1);
    chk("t4_no_write", {31'd0, a_if.imem_we}, 32'd0);
    sync();
    send(1'b0, KIND_SUB, 5'd9, 5'd10, 5'd11, 32'd0, 1'b1, 1'b1, 32'hCB0B_0149);
    idle(1'b0);
    repeat (3) @(negedge clk);
    chk("t4_count", {25'd0, count_a}, 32'd2);

    // start clears sticky flags; then reset with a write on the bus
    pulse_start(1'b0);
    @(negedge clk);
    chk("t5_err_cleared", {31'd0, err_a}, 32'd0);
    chk("t5_count_cleared", {25'd0, count_a}, 32'd0);
    sync();
    send(1'b0, KIND_ORR, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t5_write_pending", {31'd0, a_if.imem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_we", {31'd0, a_if.imem_we}, 32'd0);
    chk("t5_rst_wdata", a_if.imem_wdata, 32'd0);
    chk("t5_rst_count", {25'd0, count_a}, 32'd0);
    chk("t5_rst_ready", {31'd0, a_if.in_ready}, 32'd0);
    idle(1'b0);
    sync();
    reset_n = 1'b1;
    pulse_start(1'b0);
    send(1'b0, KIND_ADD, 5'd2, 5'd2, 5'd2, 32'd0, 1'b1, 1'b1, 32'h8B02_0042);
    idle(1'b0);
    repeat (3) @(negedge clk);

    // ADDR_W=2 overflow: four writes, fifth beat refused
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, KIND_ADD, 5'(i + 1), 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h8B03_0040 | (i + 1));
    end
    idle(1'b1);
    @(negedge clk);
    chk("t6_ready_low", {31'd0, b_if.in_ready}, 32'd0);
    chk("t6_overflow", {31'd0, ovf_b}, 32'd1);
    chk("t6_count", {29'd0, count_b}, 32'd4);
    drive(1'b1, 1'b1, KIND_ADD, 5'd5, 5'd2, 5'd3, 32'd0, 1'b0);
    seen_acc = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_if.in_ready) seen_acc = 1'b1;
      if (done_b) seen_done = 1'b1;
    end
    idle(1'b1);
    chk("t6_fifth_refused", {31'd0, seen_acc}, 32'd0);
    chk("t6_done_pulse", {31'd0, seen_done}, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_a_drained", q_a.size(), 32'd0);
    chk("sb_b_drained", q_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming LEGv8 instruction encoder and instruction-memory loader. It accepts symbolic instruction requests (kind, registers, immediate) over a valid/ready handshake and packs each into the 32-bit word the main decoder consumes. It then writes the words sequentially into instruction memory. It sits on the boot/test-load path, ahead of the fetch stage, and is the write-side counterpart of opcode decoding.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `BASE_ADDR`, default 0: first word address written after `start`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that begins a load session; honoured only in IDLE.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a clock edge.
- `in_kind`  in  4  instruction kind, from `kind_e`: ADD, SUB, AND, ORR, ADDI, LDUR, STUR, CBZ, CBNZ; other codes are illegal.
- `in_rd`  in  5  Rd/Rt.
- `in_rn`  in  5  Rn.
- `in_rm`  in  5  Rm.
- `in_imm`  in  32  signed immediate.
- `in_last`  in  1  marks the final request of the session.
- `imem_we`  out  1  write strobe.
- `imem_waddr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  number of words written this session.
- `done`  out  1  one-cycle session-complete pulse.
- `err`  out  1  sticky error; cleared by `start`.
- `overflow`  out  1  sticky; set when memory fills before `in_last`; cleared by `start`.

## Operation
- FSM states are IDLE, LOAD and DONE.
  - IDLE to LOAD: on `start`. This also clears `count`, `err` and `overflow`.
  - LOAD to DONE: on an accepted beat with `in_last`, or when `count` reaches 2**ADDR_W - BASE_ADDR.
  - DONE to IDLE: unconditionally after one cycle.
- `in_ready` = (state == LOAD) and not full. It is low in IDLE and DONE.
- Instruction formats:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): opcode[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
  - ADDI: opcode 1001000100 in [31:22], imm12 in [21:10], Rn, Rd. Legal immediate range is 0..4095.
  - D-type (LDUR 11111000010, STUR 11111000000): opcode[31:21], imm9 in [20:12], op2 in [11:10]=00, Rn, Rt. Legal immediate range is -256..255.
  - CB (CBZ 10110100, CBNZ 10110101): opcode[31:24], imm19 in [23:5], Rt[4:0]. Legal immediate range is -2**18..2**18-1.
- Fields are truncated to their width after any range check.
- An illegal kind is always accepted, not written, and sets `err`. It does not advance `count`.
- `start` in LOAD or DONE is ignored.
- If reset asserts mid-session, the block goes to IDLE and all outputs return to 0. No partial write is emitted.
- Once full: `overflow` is set, further requests are never accepted, and the FSM goes to DONE.

## Timing
- Reset value of every output is 0, including `imem_waddr` and `imem_wdata`.
- Latency is 1 cycle. A beat accepted at edge N drives `imem_we`/`imem_waddr`/`imem_wdata` during cycle N+1, from registered outputs.
- `imem_waddr` = BASE_ADDR + `count` sampled at acceptance. `count` increments at the same edge.
- Back-to-back acceptance is supported: one write per cycle, no bubbles.
- `done` is high in the DONE cycle, which is the cycle after the final write strobe.
- `err` and `overflow` are visible the cycle after the offending beat.

## Configuration
- `ENC_RANGE_CHECK_EN` defined:
  - An out-of-range immediate sets `err`.
  - The beat is accepted and dropped: no write, `count` unchanged.
- `ENC_RANGE_CHECK_EN` undefined:
  - Immediates are silently truncated and written.
  - `err` is driven only by illegal kinds.

## Structure
- Package `arki_isa_pkg` holds:
  - `kind_e`;
  - the 11/10/8-bit opcode localparams, shared with the main decoder;
  - the field-width and immediate-range constants.
- One combinational sub-module, `instr_format`, maps (kind, rd, rn, rm, imm) to (word, illegal, range_err).
- `instr_encoder` holds the FSM, counter, output register and sticky flags.

## Test plan
- ADD X1,X2,X3 with `in_last` -> one write, data 0x8B030041 at address 0. `done` pulses 2 cycles after acceptance; `count` = 1.
- Back-to-back LDUR X5,[X6,#8]; CBZ X7,#-2 -> 0xF84080C5 at address 0, then 0xB4FFFFC7 at address 1, in consecutive cycles.
- ADDI X1,X1,#4095 -> 0x913FFC21. ADDI with imm 4096:
  - with `ENC_RANGE_CHECK_EN`: no write and `err` = 1;
  - without it: 0x91000021 written.
- `ADDR_W`=2: send 5 beats with no `in_last` -> 4 writes, `overflow` = 1, `in_ready` low after the 4th acceptance, `done` pulses.
- Illegal kind 4'hF mid-stream -> no write, `err` = 1, and the next beat lands at the next sequential address.
- Assert `reset_n` low during LOAD with a write pending -> all outputs 0 immediately, state IDLE, `in_ready` = 0; a new `start` restarts at BASE_ADDR.
